// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter that funnels N requesters into one shared register,
// writing for one cycle and then checking the register's read-back value.
module reg_write_arbiter #(
  parameter int          WIDTH         = 8,
  parameter int          NUM_REQ       = 4,
  parameter logic [15:0] WR_COUNT_INIT = 16'h0000,
  localparam int         GW            = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     reg_en,
  output logic [WIDTH-1:0]         reg_d,
  input  logic [WIDTH-1:0]         reg_q,
  input  logic                     err_clr,
  output logic                     busy,
  output logic [GW-1:0]            last_grant,
  output logic                     err,
  output logic [15:0]              wr_count
);

  typedef enum logic [1:0] {IDLE, WRITE, CHECK} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] data_q;
  logic [GW-1:0]    grant;
  logic [GW-1:0]    cand;
  logic             any_valid;
  logic             accept;

  // Search begins one past the last winner so every requester gets a turn.
  always_comb begin
    grant     = last_grant;
    cand      = last_grant;
    any_valid = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = GW'((int'(last_grant) + i) % NUM_REQ);
      if (!any_valid && req_valid[cand]) begin
        any_valid = 1'b1;
        grant     = cand;
      end
    end
  end

  assign accept = (state == IDLE) && any_valid && !rst;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = accept && (grant == GW'(i));
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = WRITE;
      WRITE:   state_nx = CHECK;
      CHECK:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign reg_en = (state == WRITE);
  assign busy   = (state != IDLE);
  assign reg_d  = data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      data_q     <= '0;
      last_grant <= GW'(NUM_REQ - 1);
      err        <= 1'b0;
      wr_count   <= WR_COUNT_INIT;
    end else begin
      state <= state_nx;
      if (accept) begin
        data_q     <= req_data[int'(grant)*WIDTH +: WIDTH];
        last_grant <= grant;
      end
      // A mismatch in the same cycle as err_clr must leave err set.
      if (state == CHECK && reg_q != data_q) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
      if (state == CHECK && wr_count != 16'hFFFF) begin
        wr_count <= wr_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with a simple shared-register model;
// a second instance starts near the wr_count ceiling to exercise saturation.
module tb_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        reg_en;
  logic [7:0]  reg_d;
  logic [7:0]  reg_q;
  logic        err_clr;
  logic        busy;
  logic [1:0]  last_grant;
  logic        err;
  logic [15:0] wr_count;

  logic [3:0]  sat_ready;
  logic        sat_en;
  logic [7:0]  sat_d;
  logic        sat_busy;
  logic [1:0]  sat_last;
  logic        sat_err;
  logic [15:0] sat_count;

  logic [7:0]  shreg;
  logic        bad;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  reg_write_arbiter #(.WIDTH(8), .NUM_REQ(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .reg_en(reg_en), .reg_d(reg_d), .reg_q(reg_q),
    .err_clr(err_clr), .busy(busy), .last_grant(last_grant), .err(err),
    .wr_count(wr_count)
  );

  reg_write_arbiter #(.WIDTH(8), .NUM_REQ(4), .WR_COUNT_INIT(16'hFFFC)) u_sat (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(sat_ready), .reg_en(sat_en), .reg_d(sat_d), .reg_q(sat_d),
    .err_clr(err_clr), .busy(sat_busy), .last_grant(sat_last), .err(sat_err),
    .wr_count(sat_count)
  );

  // Shared register model; bad forces a wrong read-back.
  always_ff @(posedge clk) if (reg_en) shreg <= reg_d;
  assign reg_q = bad ? 8'h00 : shreg;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; err_clr = 1'b0; bad = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Single-requester write: accept, WRITE, CHECK (with optional faults), back to IDLE.
  task automatic do_write(input int idx, input logic [7:0] d, input logic b, input logic clr);
    req_valid = 4'b0001 << idx;
    req_data[idx*8 +: 8] = d;
    tick();
    req_valid = '0;
    tick();
    bad = b; err_clr = clr;
    tick();
    bad = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; err_clr = 1'b0; bad = 1'b0;
    tick(); tick();
    req_valid = 4'b0001;
    #1;
    chk("rst_ready", req_ready, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_en", reg_en, 1'b0);
    chk("rst_d", reg_d, 8'h00);
    chk("rst_last", last_grant, 2'd3);
    chk("rst_err", err, 1'b0);
    chk("rst_cnt", wr_count, 16'd0);
    chk("rst_sat_cnt", sat_count, 16'hFFFC);

    // Basic single write from requester 0
    rst = 1'b0; req_data[7:0] = 8'h3C;
    #1;
    chk("w1_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    chk("w1_en", reg_en, 1'b1);
    chk("w1_d", reg_d, 8'h3C);
    chk("w1_ready_wr", req_ready, 4'b0000);
    chk("w1_busy", busy, 1'b1);
    tick();
    chk("w1_en_chk", reg_en, 1'b0);
    chk("w1_d_chk", reg_d, 8'h3C);
    tick();
    chk("w1_cnt", wr_count, 16'd1);
    chk("w1_err", err, 1'b0);
    chk("w1_idle", busy, 1'b0);
    chk("w1_d_idle", reg_d, 8'h3C);

    // Idle with no requests: nothing moves
    tick(); tick();
    chk("idle_busy", busy, 1'b0);
    chk("idle_last", last_grant, 2'd0);
    chk("idle_en", reg_en, 1'b0);

    // Round robin with all four requesters valid
    do_reset();
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("rr%0d_ready", k), req_ready, 4'b0001 << (k % 4));
      tick();
      chk($sformatf("rr%0d_last", k), last_grant, k % 4);
      chk($sformatf("rr%0d_d", k), reg_d, 8'h10 + (k % 4));
      chk($sformatf("rr%0d_en", k), reg_en, 1'b1);
      tick();
      chk($sformatf("rr%0d_ready_chk", k), req_ready, 4'b0000);
      tick();
      if (k == 1) chk("sat_cnt_2", sat_count, 16'hFFFE);
      if (k == 2) chk("sat_cnt_3", sat_count, 16'hFFFF);
    end
    req_valid = '0;
    #1;
    chk("rr_cnt", wr_count, 16'd5);
    chk("sat_cnt_hold", sat_count, 16'hFFFF);
    chk("sat_err", sat_err, 1'b0);

    // Read-back mismatch handling
    do_reset();
    do_write(0, 8'hAA, 1'b1, 1'b0);
    chk("err_set", err, 1'b1);
    do_write(0, 8'h55, 1'b0, 1'b0);
    chk("err_sticky", err, 1'b1);
    chk("err_cnt", wr_count, 16'd2);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_clr", err, 1'b0);
    do_write(0, 8'h77, 1'b1, 1'b1);
    chk("err_set_wins", err, 1'b1);
    chk("err_cnt3", wr_count, 16'd3);

    // Reset during WRITE abandons the transfer
    req_valid = 4'b0100; req_data[23:16] = 8'h55;
    #1;
    chk("ab_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    chk("ab_en_wr", reg_en, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ab_en", reg_en, 1'b0);
    chk("ab_busy", busy, 1'b0);
    chk("ab_cnt", wr_count, 16'd0);
    chk("ab_last", last_grant, 2'd3);
    chk("ab_err", err, 1'b0);
    tick(); tick();
    chk("ab_cnt_late", wr_count, 16'd0);
    chk("ab_en_late", reg_en, 1'b0);

    // Requester 1 withdraws while busy; requester 3 wins
    req_data = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b1010;
    #1;
    chk("dr_ready_wr", req_ready, 4'b0000);
    tick();
    req_valid = 4'b1000;
    #1;
    chk("dr_ready_chk", req_ready, 4'b0000);
    chk("dr_en_chk", reg_en, 1'b0);
    tick();
    chk("dr_ready", req_ready, 4'b1000);
    chk("dr_en_idle", reg_en, 1'b0);
    tick();
    req_valid = '0;
    chk("dr_last", last_grant, 2'd3);
    chk("dr_d", reg_d, 8'hD3);
    tick(); tick();
    chk("dr_cnt", wr_count, 16'd2);
    chk("dr_busy", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
